// File: rtl/stage_ex.sv
// Execute stage: single-cycle ALU with register-write forwarding, plus a
// 32-step restoring divider for DIV/DIVU that stalls the pipeline until HI/LO are ready.
module stage_ex (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  operator,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        register_write_enable_,
  input  logic [4:0]  register_write_address_,
  input  logic        flush,
  output logic        register_write_enable,
  output logic [4:0]  register_write_address,
  output logic [31:0] register_write_data,
  output logic        hilo_write_enable,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        stall_request
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_DIV  = 4'd12,
    OP_DIVU = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  op_e op;
  assign op = op_e'(operator);

  // ---------------------------------------------------------------------------
  // ALU path (purely combinational)
  // ---------------------------------------------------------------------------
  logic [31:0] alu_result;
  logic        alu_valid;
  logic [4:0]  shamt;

  assign shamt = operand_a[4:0];

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_result = '0;
    alu_valid  = 1'b1;
    unique case (op)
      OP_ADD:  alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_AND:  alu_result = operand_a & operand_b;
      OP_OR:   alu_result = operand_a | operand_b;
      OP_XOR:  alu_result = operand_a ^ operand_b;
      OP_NOR:  alu_result = ~(operand_a | operand_b);
      OP_SLT:  alu_result = {31'b0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_result = {31'b0, operand_a < operand_b};
      OP_SLL:  alu_result = operand_b << shamt;
      OP_SRL:  alu_result = operand_b >> shamt;
      OP_SRA:  alu_result = $signed(operand_b) >>> shamt;
      default: alu_valid  = 1'b0;
    endcase
  end

  assign register_write_enable  = !reset && alu_valid && register_write_enable_;
  assign register_write_address = reset ? 5'd0 : register_write_address_;
  assign register_write_data    = (reset || !alu_valid) ? 32'd0 : alu_result;

  // ---------------------------------------------------------------------------
  // Sequential restoring divider
  // ---------------------------------------------------------------------------
  div_state_e  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        is_signed_q, is_signed_d;

  logic        is_div_op;
  logic        is_signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] rem_next;
  logic [31:0] quot_fixed, rem_fixed;

  assign is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed_op = (op == OP_DIV);
  assign a_mag = (is_signed_op && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign b_mag = (is_signed_op && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign trial    = {remainder_q, dividend_q[31]};
  assign diff     = trial - {1'b0, divisor_q};
  assign take     = ~diff[32];
  assign rem_next = take ? diff[31:0] : trial[31:0];

  assign quot_fixed = (is_signed_q && (sign_a_q ^ sign_b_q)) ? (~quotient_q + 32'd1) : quotient_q;
  assign rem_fixed  = (is_signed_q && sign_a_q) ? (~remainder_q + 32'd1) : remainder_q;

  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    dividend_d        = dividend_q;
    divisor_d         = divisor_q;
    quotient_d        = quotient_q;
    remainder_d       = remainder_q;
    sign_a_d          = sign_a_q;
    sign_b_d          = sign_b_q;
    is_signed_d       = is_signed_q;
    stall_request     = 1'b0;
    hilo_write_enable = 1'b0;
    hi_data           = '0;
    lo_data           = '0;

    unique case (state_q)
      IDLE: begin
        if (is_div_op && !flush) begin
          stall_request = 1'b1;
          is_signed_d   = is_signed_op;
          sign_a_d      = operand_a[31];
          sign_b_d      = operand_b[31];
          count_d       = '0;
          quotient_d    = '0;
          remainder_d   = '0;
          if (operand_b != 32'd0) begin
            dividend_d = a_mag;
            divisor_d  = b_mag;
            state_d    = BUSY;
          end else begin
            state_d    = DONE;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall_request = 1'b1;
          dividend_d    = {dividend_q[30:0], 1'b0};
          remainder_d   = rem_next;
          quotient_d    = {quotient_q[30:0], take};
          count_d       = count_q + 6'd1;
          if (count_q == 6'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          hilo_write_enable = 1'b1;
          hi_data           = rem_fixed;
          lo_data           = quot_fixed;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides everything visible downstream in the cycle it is asserted.
    if (reset) begin
      stall_request     = 1'b0;
      hilo_write_enable = 1'b0;
      hi_data           = '0;
      lo_data           = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the datapath registers are few and cheap, so they are reset along with the FSM.
      state_q     <= IDLE;
      count_q     <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_signed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      is_signed_q <= is_signed_d;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed and random ALU/divider stimulus
// compared against a plain-arithmetic reference model.
module tb_stage_ex;

  logic        clock;
  logic        reset;
  logic [3:0]  operator;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        register_write_enable_;
  logic [4:0]  register_write_address_;
  logic        flush;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
  logic        hilo_write_enable;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        stall_request;

  int tests  = 0;
  int failed = 0;

  stage_ex dut (
    .clock                   (clock),
    .reset                   (reset),
    .operator                (operator),
    .operand_a               (operand_a),
    .operand_b               (operand_b),
    .register_write_enable_  (register_write_enable_),
    .register_write_address_ (register_write_address_),
    .flush                   (flush),
    .register_write_enable   (register_write_enable),
    .register_write_address  (register_write_address),
    .register_write_data     (register_write_data),
    .hilo_write_enable       (hilo_write_enable),
    .hi_data                 (hi_data),
    .lo_data                 (lo_data),
    .stall_request           (stall_request)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] addr, input logic fl, input logic rst);
    @(negedge clock);
    operator                = op;
    operand_a               = a;
    operand_b               = b;
    register_write_enable_  = we;
    register_write_address_ = addr;
    flush                   = fl;
    reset                   = rst;
    #1;
  endtask

  // Reference ALU, {write_enable, data}, from the arithmetic meaning of each op.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic we);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int     sh = int'(a[4:0]);
    logic [31:0] r = '0;
    logic        v = 1'b1;
    case (op)
      4'd1:    r = 32'(ua + ub);
      4'd2:    r = 32'(ua - ub);
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd6:    r = ~(a | b);
      4'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:    r = (ua < ub) ? 32'd1 : 32'd0;
      4'd9:    r = 32'(ub * (longint'(1) << sh));
      4'd10:   r = 32'(ub / (longint'(1) << sh));
      4'd11:   r = 32'(sb >>> sh);
      default: begin r = '0; v = 1'b0; end
    endcase
    return {v & we, r};
  endfunction

  // Reference divide: truncating division, remainder follows the dividend.
  task automatic div_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (op == 4'd13) begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    if (y == 0) begin
      q = '0;
      r = '0;
    end else begin
      q = 32'(x / y);
      r = 32'(x % y);
    end
  endtask

  task automatic alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input logic [4:0] addr);
    logic [32:0] e;
    drive(op, a, b, we, addr, 1'b0, 1'b0);
    e = alu_ref(op, a, b, we);
    chk_bit("alu_we", register_write_enable, e[32]);
    chk("alu_addr", {27'b0, register_write_address}, {27'b0, addr});
    chk("alu_data", register_write_data, e[31:0]);
    chk_bit("alu_stall", stall_request, 1'b0);
    chk_bit("alu_hilo_we", hilo_write_enable, 1'b0);
  endtask

  // Issue a divide in an IDLE cycle and follow it to its HI/LO write.
  task automatic div_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int n;
    div_ref(op, a, b, eq, er);
    n = (b == 32'd0) ? 1 : 33;
    for (int k = 0; k <= n; k++) begin
      if (k == 0) drive(op, a, b, 1'b1, 5'd9, 1'b0, 1'b0);
      else begin
        @(negedge clock);
        #1;
      end
      chk_bit("div_stall", stall_request, k < n);
      chk_bit("div_hilo_we", hilo_write_enable, k == n);
      chk("div_hi", hi_data, (k == n) ? er : 32'd0);
      chk("div_lo", lo_data, (k == n) ? eq : 32'd0);
      chk_bit("div_rwe", register_write_enable, 1'b0);
      chk("div_rdata", register_write_data, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; flush = 1'b0; operator = 4'd1;
    operand_a = 32'h1234_5678; operand_b = 32'h1111_1111;
    register_write_enable_ = 1'b1; register_write_address_ = 5'd7;

    // Reset forces every output to zero even with a live ALU op on the inputs.
    drive(4'd1, 32'h1234_5678, 32'h1111_1111, 1'b1, 5'd7, 1'b0, 1'b1);
    drive(4'd12, 32'd50, 32'd5, 1'b1, 5'd7, 1'b0, 1'b1);
    chk_bit("rst_rwe", register_write_enable, 1'b0);
    chk("rst_addr", {27'b0, register_write_address}, 32'd0);
    chk("rst_data", register_write_data, 32'd0);
    chk_bit("rst_hilo_we", hilo_write_enable, 1'b0);
    chk("rst_hi", hi_data, 32'd0);
    chk("rst_lo", lo_data, 32'd0);
    chk_bit("rst_stall", stall_request, 1'b0);

    alu_step(4'd0, 32'hDEAD_BEEF, 32'h1, 1'b1, 5'd3);

    // Directed ALU cases with hand-computed results.
    drive(4'd1, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("add_ovf_data", register_write_data, 32'h8000_0000);
    chk_bit("add_ovf_we", register_write_enable, 1'b1);
    chk("add_ovf_addr", {27'b0, register_write_address}, 32'd5);
    drive(4'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("slt_neg", register_write_data, 32'd1);
    drive(4'd8, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("sltu_big", register_write_data, 32'd0);
    drive(4'd11, 32'd4, 32'h8000_0000, 1'b1, 5'd6, 1'b0, 1'b0);
    chk("sra_sign", register_write_data, 32'hF800_0000);
    drive(4'd6, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    chk("nor_zero", register_write_data, 32'hFFFF_FFFF);
    drive(4'd15, 32'd3, 32'd4, 1'b1, 5'd6, 1'b0, 1'b0);
    chk_bit("op15_we", register_write_enable, 1'b0);
    chk("op15_data", register_write_data, 32'd0);

    // Divides: signed negative, unsigned wide, divide by zero, back-to-back.
    div_run(4'd12, 32'hFFFF_FFF9, 32'd2);
    div_run(4'd13, 32'hFFFF_FFFF, 32'h10);
    div_run(4'd12, 32'd100, 32'd0);
    div_run(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    div_run(4'd12, 32'd77, 32'hFFFF_FFF6);

    // Flush at BUSY cycle 10 aborts; a new DIVU is accepted right after.
    drive(4'd13, 32'hCAFE_F00D, 32'd123, 1'b0, 5'd1, 1'b0, 1'b0);
    chk_bit("fl_stall0", stall_request, 1'b1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      #1;
      chk_bit("fl_stall_busy", stall_request, 1'b1);
      chk_bit("fl_hilo_busy", hilo_write_enable, 1'b0);
    end
    drive(4'd13, 32'hCAFE_F00D, 32'd123, 1'b0, 5'd1, 1'b1, 1'b0);
    chk_bit("fl_stall_drop", stall_request, 1'b0);
    chk_bit("fl_hilo", hilo_write_enable, 1'b0);
    div_run(4'd13, 32'd1000, 32'd7);

    // Reset at BUSY cycle 20 drops the divide.
    drive(4'd12, 32'd12345, 32'd17, 1'b1, 5'd2, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) begin
      @(negedge clock);
      #1;
      chk_bit("rs_stall_busy", stall_request, 1'b1);
    end
    drive(4'd12, 32'd12345, 32'd17, 1'b1, 5'd2, 1'b0, 1'b1);
    chk_bit("rs_mid_stall", stall_request, 1'b0);
    chk_bit("rs_mid_hilo", hilo_write_enable, 1'b0);
    chk("rs_mid_addr", {27'b0, register_write_address}, 32'd0);
    chk("rs_mid_hi", hi_data, 32'd0);
    chk("rs_mid_lo", lo_data, 32'd0);
    alu_step(4'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    div_run(4'd12, 32'd9, 32'd3);

    // Random ALU traffic, including the NOP-like codes 14/15.
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op == 4'd12) op = 4'd14;
      if (op == 4'd13) op = 4'd15;
      alu_step(op, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // Random divides, occasionally by zero.
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'd12 : 4'd13;
      a  = rand_word();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if (b == 32'd0 && i == 0) b = 32'd3;
      div_run(op, a, b);
    end

    drive(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_bit("end_stall", stall_request, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
